// File: rtl/riu_pkg.sv
// rtl/riu_pkg.sv - shared writeback types and constants
package riu_pkg;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic             live;
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular load-result buffer with per-entry live bits
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_rd,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  input  logic                       kill,
  input  logic [AW-1:0]              kill_rd,
  input  logic [AW-1:0]              match_rd1,
  input  logic [AW-1:0]              match_rd2,
  output logic                       match1,
  output logic                       match2,
  output logic                       head_live,
  output logic [AW-1:0]              head_rd,
  output logic [DW-1:0]              head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import riu_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic          live_q [DEPTH];
  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign head_live = live_q[rd_ptr];
  assign head_rd   = rd_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Popped slots are cleared so stale contents never produce a hazard hit.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && rd_q[i] == match_rd1 && match_rd1 != AW'(REG_ZERO)) match1 = 1'b1;
      if (live_q[i] && rd_q[i] == match_rd2 && match_rd2 != AW'(REG_ZERO)) match2 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i] <= 1'b0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill && rd_q[i] == kill_rd) live_q[i] <= 1'b0;
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= bump(rd_ptr);
      end
      if (push) begin
        live_q[wr_ptr] <= 1'b1;
        rd_q[wr_ptr]   <= push_rd;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= bump(wr_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback port arbiter merging ALU results and buffered loads
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_rd,
  input  logic [DW-1:0]              alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [AW-1:0]              lsu_rd,
  input  logic [DW-1:0]              lsu_data,
  output logic                       we,
  output logic [AW-1:0]              writeaddr,
  output logic [DW-1:0]              writedata,
  input  logic [AW-1:0]              qaddr1,
  input  logic [AW-1:0]              qaddr2,
  output logic                       qhit1,
  output logic                       qhit2,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  import riu_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  logic          alu_wr, lsu_fire, lsu_drop, buf_empty, bypass, push, pop;
  logic          head_live;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;

  assign lsu_ready = !rst && (occupancy < CW'(DEPTH));
  assign alu_wr    = alu_valid && (alu_rd != AW'(REG_ZERO));
  assign lsu_fire  = lsu_valid && lsu_ready;
  // x0 loads and loads overwritten by a same-cycle ALU write are accepted but discarded.
  assign lsu_drop  = (lsu_rd == AW'(REG_ZERO)) || (alu_wr && lsu_rd == alu_rd);
  assign buf_empty = (occupancy == '0);
  assign pop       = !alu_wr && !buf_empty;
  assign bypass    = !alu_wr && buf_empty && lsu_fire && !lsu_drop;
  assign push      = lsu_fire && !lsu_drop && !bypass;

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (pop),
    .kill      (alu_wr),
    .kill_rd   (alu_rd),
    .match_rd1 (qaddr1),
    .match_rd2 (qaddr2),
    .match1    (qhit1),
    .match2    (qhit2),
    .head_live (head_live),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we        <= 1'b0;
      writeaddr <= '0;
      writedata <= '0;
    end else if (alu_wr) begin
      we        <= 1'b1;
      writeaddr <= alu_rd;
      writedata <= alu_data;
    end else if (pop) begin
      we <= head_live;
      if (head_live) begin
        writeaddr <= head_rd;
        writedata <= head_data;
      end
    end else if (bypass) begin
      we        <= 1'b1;
      writeaddr <= lsu_rd;
      writedata <= lsu_data;
    end else begin
      we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        we;
  logic [4:0]  writeaddr;
  logic [31:0] writedata;
  logic [4:0]  qaddr1 = '0;
  logic [4:0]  qaddr2 = '0;
  logic        qhit1, qhit2;
  logic [1:0]  occupancy;

  wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we(we), .writeaddr(writeaddr), .writedata(writedata),
    .qaddr1(qaddr1), .qaddr2(qaddr2), .qhit1(qhit1), .qhit2(qhit2),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          last_fire;

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic [4:0] q1;
    logic rdy; logic h1;
    logic we; logic [4:0] wa; logic [31:0] wd; logic [1:0] occ;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [4:0] a);
    if (a == 0) return 0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == a) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we = 0; m_addr = '0; m_data = '0;
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic cycle();
    bit rdy, awr, fire;
    ent_t e;
    #2;
    rdy = (mq.size() < DEPTH);
    chk("lsu_ready", lsu_ready, rdy);
    chk("qhit1", qhit1, model_hit(qaddr1));
    chk("qhit2", qhit2, model_hit(qaddr2));
    awr  = alu_valid && alu_rd != 0;
    fire = lsu_valid && rdy;
    last_fire = fire;
    if (awr) begin
      m_we = 1; m_addr = alu_rd; m_data = alu_data;
      foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = e.live;
      if (e.live) begin m_addr = e.rd; m_data = e.data; end
    end else if (fire && lsu_rd != 0) begin
      m_we = 1; m_addr = lsu_rd; m_data = lsu_data;
      fire = 0;
    end else begin
      m_we = 0;
    end
    if (fire && lsu_rd != 0 && !(awr && lsu_rd == alu_rd))
      mq.push_back('{live: 1'b1, rd: lsu_rd, data: lsu_data});
    @(posedge clk); #1;
    chk("we", we, m_we);
    if (m_we) begin
      chk("writeaddr", writeaddr, m_addr);
      chk("writedata", writedata, m_data);
    end
    chk("occupancy", occupancy, mq.size());
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] q1, input logic [4:0] q2);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    qaddr1 = q1; qaddr2 = q2;
  endtask

  task automatic add(input logic av, input int ard, input logic [31:0] ad,
                     input logic lv, input int lrd, input logic [31:0] ld, input int q1,
                     input logic rdy, input logic h1,
                     input logic w, input int wa, input logic [31:0] wd, input int occ);
    vec_t v;
    v.av = av; v.ard = 5'(ard); v.ad = ad;
    v.lv = lv; v.lrd = 5'(lrd); v.ld = ld; v.q1 = 5'(q1);
    v.rdy = rdy; v.h1 = h1;
    v.we = w; v.wa = 5'(wa); v.wd = wd; v.occ = 2'(occ);
    tv.push_back(v);
  endtask

  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;

  initial begin
    // ALU only, then LSU bypass
    add(1, 6, 32'hDEADBEEF, 0, 0, 0,             0, 1, 0, 1, 6, 32'hDEADBEEF, 0);
    add(0, 0, 0,            1, 5, 32'h12345678,  0, 1, 0, 1, 5, 32'h12345678, 0);
    // contention: ALU busy 4 cycles, loads 7, 8, 9 back to back
    add(1, 1, 32'h101, 1, 7, 32'h700, 7, 1, 0, 1, 1, 32'h101, 1);
    add(1, 2, 32'h102, 1, 8, 32'h800, 7, 1, 1, 1, 2, 32'h102, 2);
    add(1, 3, 32'h103, 1, 9, 32'h900, 7, 0, 1, 1, 3, 32'h103, 2);
    add(1, 4, 32'h104, 1, 9, 32'h900, 7, 0, 1, 1, 4, 32'h104, 2);
    add(0, 0, 0,       1, 9, 32'h900, 7, 0, 1, 1, 7, 32'h700, 1);
    add(0, 0, 0,       1, 9, 32'h900, 7, 1, 0, 1, 8, 32'h800, 1);
    add(0, 0, 0,       0, 0, 0,       7, 1, 0, 1, 9, 32'h900, 0);
    // WAW: buffered load to x3 killed by ALU write to x3
    add(1, 10, 32'h10A, 1, 3, 32'h333, 3, 1, 0, 1, 10, 32'h10A, 1);
    add(1, 3,  32'hAA,  0, 0, 0,       3, 1, 1, 1, 3,  32'hAA,  1);
    add(0, 0,  0,       0, 0, 0,       3, 1, 0, 0, 0,  0,       0);
    // same-cycle load and ALU write to x3
    add(1, 3,  32'hAA,  1, 3, 32'h3333, 3, 1, 0, 1, 3, 32'hAA, 0);
    add(0, 0,  0,       0, 0, 0,        3, 1, 0, 0, 0, 0,      0);
    // x0: ALU rd=0 frees the port for buffered x9; load to x0 is dropped
    add(1, 11, 32'hB,   1, 9, 32'h999, 9, 1, 0, 1, 11, 32'hB,   1);
    add(1, 0,  32'h5,   0, 0, 0,       9, 1, 1, 1, 9,  32'h999, 0);
    add(0, 0,  0,       1, 0, 32'h77,  0, 1, 0, 0, 0,  0,       0);
    add(0, 0,  0,       0, 0, 0,       0, 1, 0, 0, 0,  0,       0);

    #3;
    chk("rst_we", we, 0);
    chk("rst_writeaddr", writeaddr, 0);
    chk("rst_writedata", writedata, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model_reset();

    foreach (tv[i]) begin
      drive(tv[i].av, tv[i].ard, tv[i].ad, tv[i].lv, tv[i].lrd, tv[i].ld, tv[i].q1, 5'd0);
      #1;
      chk($sformatf("tv%0d_ready", i), lsu_ready, tv[i].rdy);
      chk($sformatf("tv%0d_qhit1", i), qhit1, tv[i].h1);
      cycle();
      chk($sformatf("tv%0d_we", i), we, tv[i].we);
      if (tv[i].we) begin
        chk($sformatf("tv%0d_addr", i), writeaddr, tv[i].wa);
        chk($sformatf("tv%0d_data", i), writedata, tv[i].wd);
      end
      chk($sformatf("tv%0d_occ", i), occupancy, tv[i].occ);
    end

    // reset mid-stream with a full buffer
    drive(1, 5'd1, 32'h1, 1, 5'd12, 32'hC00, 5'd12, 5'd13); cycle();
    drive(1, 5'd2, 32'h2, 1, 5'd13, 32'hD00, 5'd12, 5'd13); cycle();
    chk("full_occ", occupancy, 2);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd12, 5'd13);
    #2; rst = 1'b1; #1;
    chk("midrst_we", we, 0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_ready", lsu_ready, 0);
    chk("midrst_qhit1", qhit1, 0);
    #1; rst = 1'b0; #1;
    chk("postrst_ready", lsu_ready, 1);
    model_reset();
    for (int i = 0; i < 3; i++) cycle();

    // randomized traffic; producer holds each load until accepted
    p_valid = 0; p_rd = '0; p_data = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p_valid && ($urandom % 2 == 1)) begin
        p_valid = 1;
        p_rd    = 5'($urandom_range(0, 7));
        p_data  = $urandom;
      end
      drive(($urandom % 2 == 1), 5'($urandom_range(0, 7)), $urandom,
            p_valid, p_rd, p_data,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle();
      if (last_fire) p_valid = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
